// File: rtl/clean_cycle_executor.sv
// Hood self-clean sequencer: arming warning, timed motor run, done hold.
// Reports normal completion or cancellation to the mode controller with one-cycle pulses.
module clean_cycle_executor #(
   parameter int CLEAN_DURATION_S = 180,
   parameter int ARM_S            = 2,
   parameter int DONE_HOLD_S      = 3,
   parameter int TIME_W           = 9
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clean_mode_toggle,
   input  logic              tick_1s,
   input  logic              abort,
   output logic              clean_active,
   output logic              motor_en,
   output logic              buzzer,
   output logic [TIME_W-1:0] remaining_s,
   output logic [1:0]        clean_state,
   output logic              clean_done,
   output logic              clean_aborted
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ARM  = 2'd1,
      ST_RUN  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   localparam logic [TIME_W-1:0] ARM_L  = TIME_W'(ARM_S);
   localparam logic [TIME_W-1:0] RUN_L  = TIME_W'(CLEAN_DURATION_S);
   localparam logic [TIME_W-1:0] HOLD_L = TIME_W'(DONE_HOLD_S);
   localparam logic [TIME_W-1:0] ONE    = TIME_W'(1);
   localparam logic [TIME_W-1:0] ZERO   = '0;

   state_t            state_q, state_d;
   logic [TIME_W-1:0] arm_cnt_q, arm_cnt_d;
   logic [TIME_W-1:0] rem_q, rem_d;
   logic [TIME_W-1:0] done_cnt_q, done_cnt_d;
   logic              done_pulse_q, done_pulse_d;
   logic              abort_pulse_q, abort_pulse_d;
   logic              cancel;

   assign cancel = abort | clean_mode_toggle;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         arm_cnt_q     <= '0;
         rem_q         <= '0;
         done_cnt_q    <= '0;
         done_pulse_q  <= 1'b0;
         abort_pulse_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         arm_cnt_q     <= arm_cnt_d;
         rem_q         <= rem_d;
         done_cnt_q    <= done_cnt_d;
         done_pulse_q  <= done_pulse_d;
         abort_pulse_q <= abort_pulse_d;
      end
   end

   always_comb begin
      state_d       = state_q;
      arm_cnt_d     = arm_cnt_q;
      rem_d         = rem_q;
      done_cnt_d    = done_cnt_q;
      done_pulse_d  = 1'b0;
      abort_pulse_d = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (clean_mode_toggle && !abort) begin
               arm_cnt_d = ARM_L;
               rem_d     = RUN_L;
               state_d   = (ARM_S == 0) ? ST_RUN : ST_ARM;
            end
         end
         ST_ARM: begin
            if (cancel) begin
               state_d       = ST_IDLE;
               rem_d         = ZERO;
               abort_pulse_d = 1'b1;
            end else if (tick_1s && arm_cnt_q != ZERO) begin
               arm_cnt_d = arm_cnt_q - ONE;
               if (arm_cnt_q == ONE) state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            // Cancel wins even over the final tick, so the cycle reports abort rather than done.
            if (cancel) begin
               state_d       = ST_IDLE;
               rem_d         = ZERO;
               abort_pulse_d = 1'b1;
            end else if (tick_1s && rem_q != ZERO) begin
               rem_d = rem_q - ONE;
               if (rem_q == ONE) begin
                  state_d      = ST_DONE;
                  done_cnt_d   = HOLD_L;
                  done_pulse_d = 1'b1;
               end
            end
         end
         ST_DONE: begin
            rem_d = ZERO;
            if (done_cnt_q == ZERO) begin
               state_d = ST_IDLE;
            end else if (tick_1s) begin
               done_cnt_d = done_cnt_q - ONE;
               if (done_cnt_q == ONE) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   assign clean_state   = state_q;
   assign clean_active  = (state_q == ST_ARM) || (state_q == ST_RUN);
   assign motor_en      = (state_q == ST_RUN);
   assign buzzer        = (state_q == ST_ARM) || (state_q == ST_DONE);
   assign remaining_s   = rem_q;
   assign clean_done    = done_pulse_q;
   assign clean_aborted = abort_pulse_q;

endmodule

// File: tb/tb_clean_cycle_executor.sv
// Directed bench for clean_cycle_executor with hand-computed expectations;
// a second instance covers the ARM_S=0 variant.
module tb_clean_cycle_executor;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tog = 1'b0;
   logic       tog2 = 1'b0;
   logic       tick = 1'b0;
   logic       abrt = 1'b0;
   logic       active, motor, buzz, done, aborted;
   logic [8:0] rem;
   logic [1:0] st;
   logic       active2, motor2, buzz2, done2, aborted2;
   logic [8:0] rem2;
   logic [1:0] st2;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   clean_cycle_executor #(.CLEAN_DURATION_S(5), .ARM_S(2), .DONE_HOLD_S(1), .TIME_W(9)) dut (
      .clk(clk), .rst(rst), .clean_mode_toggle(tog), .tick_1s(tick), .abort(abrt),
      .clean_active(active), .motor_en(motor), .buzzer(buzz), .remaining_s(rem),
      .clean_state(st), .clean_done(done), .clean_aborted(aborted));

   clean_cycle_executor #(.CLEAN_DURATION_S(5), .ARM_S(0), .DONE_HOLD_S(1), .TIME_W(9)) dut_noarm (
      .clk(clk), .rst(rst), .clean_mode_toggle(tog2), .tick_1s(tick), .abort(abrt),
      .clean_active(active2), .motor_en(motor2), .buzzer(buzz2), .remaining_s(rem2),
      .clean_state(st2), .clean_done(done2), .clean_aborted(aborted2));

   task automatic check(input string tag, input int got, input int exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   // Advance one clock, then drop all one-cycle request inputs.
   task automatic step();
      @(posedge clk);
      #1;
      tog  = 1'b0;
      tog2 = 1'b0;
      tick = 1'b0;
      abrt = 1'b0;
   endtask

   task automatic go_run();
      tog = 1'b1; step();
      tick = 1'b1; step();
      tick = 1'b1; step();
   endtask

   initial begin
      #1;
      check("rst_state", st, 0);
      check("rst_outs", {active, motor, buzz, done, aborted}, 0);
      check("rst_rem", rem, 0);
      step();
      rst = 1'b0;
      step();

      // Full cycle
      tog = 1'b1; step();
      check("t1_arm_state", st, 1);
      check("t1_arm_buzz_active", {buzz, active, motor}, 3'b110);
      check("t1_arm_rem", rem, 5);
      tick = 1'b1; step();
      check("t1_arm_after_tick1", st, 1);
      tick = 1'b1; step();
      check("t1_run_state", st, 2);
      check("t1_run_motor_buzz", {motor, buzz}, 2'b10);
      check("t1_run_rem", rem, 5);
      for (int i = 4; i >= 1; i--) begin
         tick = 1'b1; step();
         check("t1_run_rem_dec", rem, i);
      end
      tick = 1'b1; step();
      check("t1_done_state", st, 3);
      check("t1_done_pulse", {done, aborted}, 2'b10);
      check("t1_done_rem", rem, 0);
      check("t1_done_buzz_motor", {buzz, motor}, 2'b10);
      abrt = 1'b1; step();
      check("t1_done_ignores_abort", st, 3);
      check("t1_done_single_pulse", {done, aborted}, 2'b00);
      tick = 1'b1; step();
      check("t1_idle_state", st, 0);
      check("t1_idle_outs", {active, motor, buzz, done, aborted}, 0);
      check("t1_idle_rem", rem, 0);

      // Abort in RUN at remaining_s=3
      go_run();
      tick = 1'b1; step();
      tick = 1'b1; step();
      check("t2_rem_before_abort", rem, 3);
      abrt = 1'b1; step();
      check("t2_state", st, 0);
      check("t2_motor", motor, 0);
      check("t2_rem", rem, 0);
      check("t2_pulses", {done, aborted}, 2'b01);
      step();
      check("t2_pulse_once", aborted, 0);

      // Second toggle in ARM
      tog = 1'b1; step();
      check("t3_arm", st, 1);
      tog = 1'b1; step();
      check("t3_state", st, 0);
      check("t3_pulses", {done, aborted}, 2'b01);
      step();

      // Final tick together with abort
      go_run();
      for (int i = 0; i < 4; i++) begin
         tick = 1'b1; step();
      end
      check("t4_rem_one", rem, 1);
      tick = 1'b1; abrt = 1'b1; step();
      check("t4_state", st, 0);
      check("t4_pulses", {done, aborted}, 2'b01);
      step();
      check("t4_no_late_done", {done, aborted}, 2'b00);

      // Async reset mid-RUN
      go_run();
      check("t5_in_run", motor, 1);
      #2 rst = 1'b1;
      #1;
      check("t5_async_outs", {motor, active}, 2'b00);
      check("t5_async_rem", rem, 0);
      step();
      rst = 1'b0;
      step();
      check("t5_state", st, 0);
      check("t5_no_pulses", {done, aborted}, 2'b00);

      // Toggle with abort in IDLE stays idle
      tog = 1'b1; abrt = 1'b1; step();
      check("t6_toggle_abort_idle", st, 0);
      check("t6_toggle_abort_nopulse", aborted, 0);

      // Toggle and tick together in IDLE: tick not consumed
      tog = 1'b1; tick = 1'b1; step();
      check("t6_arm", st, 1);
      check("t6_arm_rem", rem, 5);
      tick = 1'b1; step();
      check("t6_still_arm", st, 1);
      tick = 1'b1; step();
      check("t6_run", st, 2);
      abrt = 1'b1; step();
      check("t6_cleanup", st, 0);

      // ARM_S=0 goes straight to RUN
      tog2 = 1'b1; step();
      check("t6_noarm_state", st2, 2);
      check("t6_noarm_rem", rem2, 5);
      check("t6_noarm_motor_buzz", {motor2, buzz2}, 2'b10);
      check("t6_other_idle", st, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/clean_cycle_executor.md
Name: clean_cycle_executor

Overview:
- Consumer end of the clean-mode request path. Takes the one-cycle `clean_mode_toggle` request issued in standby and runs the hood self-clean cycle: warning/arming period, timed motor run, done indication.
- Reports completion or abort back to the mode controller so it can return to standby.
- Drives clean motor enable, buzzer and the remaining-seconds value for the display path.

Parameters:
- CLEAN_DURATION_S, 180: length of motor run phase in seconds (must be ≥1).
- ARM_S, 2: warning period before motor start, in seconds (0 = skip).
- DONE_HOLD_S, 3: seconds the done indication is held before returning to idle (0 = one cycle).
- TIME_W, 9: width of second counters and remaining_s (must hold the largest parameter).

Ports:
- clk  input  1  system clock.
- rst  input  1  asynchronous, active-high reset.
- clean_mode_toggle  input  1  one-cycle clean request/cancel pulse.
- tick_1s  input  1  one-cycle pulse, once per second.
- abort  input  1  level; forced cancel (power-off, fault).
- clean_active  output  1  high in ARM and RUN.
- motor_en  output  1  clean motor drive; high only in RUN.
- buzzer  output  1  high in ARM and DONE.
- remaining_s  output  TIME_W  seconds left in the run phase.
- clean_state  output  2  IDLE=0, ARM=1, RUN=2, DONE=3.
- clean_done  output  1  one-cycle pulse, normal completion.
- clean_aborted  output  1  one-cycle pulse, cancelled cycle.

Behaviour:
- Reset (async, rst=1): state IDLE; all outputs 0; internal counters 0. Reset mid-cycle drops motor_en at once, with no pulses.
- All outputs are registered or decoded from the registered state. There is no combinational path from an input to an output.
- IDLE:
  - On clean_mode_toggle=1 with abort=0, the next state is ARM. The arm counter loads ARM_S and remaining_s loads CLEAN_DURATION_S.
  - If ARM_S=0, the next state is RUN instead.
  - tick_1s arriving in the same cycle is ignored.
  - toggle with abort=1 stays in IDLE.
- ARM:
  - Each tick_1s decrements the arm counter.
  - A tick seen while the counter is 1 moves to RUN.
  - remaining_s holds at CLEAN_DURATION_S.
- RUN:
  - Each tick_1s decrements remaining_s.
  - A tick seen while remaining_s is 1 sets remaining_s to 0 and moves to DONE.
  - clean_done is high for exactly the first DONE cycle.
  - The done counter loads DONE_HOLD_S.
- DONE:
  - Each tick decrements the done counter. A tick seen while the counter is 1 moves to IDLE.
  - If DONE_HOLD_S=0, the block returns to IDLE after one cycle.
  - Toggle and abort are ignored.
  - remaining_s stays 0.
- Cancel (from ARM or RUN): either abort=1 or clean_mode_toggle=1 counts as a cancel.
  - Next state is IDLE and remaining_s clears to 0.
  - clean_aborted pulses for one cycle, in the first IDLE cycle.
  - Cancel has priority over tick_1s in the same cycle. It also has priority over the final RUN tick, so that cycle reports abort, not done.
- clean_done and clean_aborted are never high together. Each fires at most once per cycle of operation.
- Counters never wrap. Decrement happens only when the counter is nonzero.

Test Plan (CLEAN_DURATION_S=5, ARM_S=2, DONE_HOLD_S=1, TIME_W=9):
1. Full cycle:
   - Stimulus: toggle pulse, then 8 ticks.
   - Response: state ARM (buzzer=1, remaining_s=5) → RUN after tick 2 (motor_en=1) → remaining_s 4,3,2,1,0 on ticks 3–7 → DONE with single clean_done pulse → IDLE after tick 8, outputs 0.
2. Abort in RUN:
   - Stimulus: abort=1 when remaining_s=3.
   - Response: next cycle IDLE, motor_en=0, remaining_s=0, one clean_aborted pulse, no clean_done.
3. Second toggle in ARM:
   - Stimulus: toggle pulse during ARM.
   - Response: cancel to IDLE with clean_aborted pulse.
4. Simultaneous events in RUN:
   - Stimulus: final tick (remaining_s=1) together with abort.
   - Response: IDLE, clean_aborted=1, clean_done stays 0.
5. Async reset mid-RUN:
   - Stimulus: rst=1 between clock edges.
   - Response: motor_en, clean_active and remaining_s are 0 immediately. After release, state is IDLE and no pulses fire.
6. Same-cycle toggle and tick in IDLE, and ARM_S=0 variant:
   - Stimulus: toggle+tick together in IDLE.
   - Response: enter ARM with arm counter 2, tick not consumed. With ARM_S=0, go straight to RUN with remaining_s=5.
